ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Two-port arbiter sharing one byte-wide data RAM between the CPU core data port (port A)
//  and a loader/debug port (port B). Each requester issues a one-cycle read/write strobe
//  with address/data valid only in that cycle, then waits for a one-cycle done pulse.
//  The arbiter latches requests, grants round-robin and runs one RAM transaction at a time.
// PARAMETERS
//  ADDR_W          16   address width, both ports and RAM side
//  DATA_W          8    data width
//  TIMEOUT_CYCLES  255  WAIT-state cycle limit; used only when RAM_ARB_TIMEOUT_EN is defined
// PORTS
//  i_clk        in   1       clock, all state on rising edge
//  i_rst        in   1       reset, asynchronous, active-high
//  i_a_addr     in   ADDR_W  port A address, valid with strobe
//  i_a_wdata    in   DATA_W  port A write data, valid with i_a_write
//  i_a_read     in   1       port A read strobe (single cycle)
//  i_a_write    in   1       port A write strobe (single cycle)
//  o_a_rdata    out  DATA_W  port A read data, valid from o_a_done, held until next A completion
//  o_a_done     out  1       port A completion pulse, one cycle
//  i_b_* / o_b_*             port B, identical to port A
//  o_mem_addr   out  ADDR_W  RAM address, stable ISSUE through WAIT
//  o_mem_wdata  out  DATA_W  RAM write data, stable ISSUE through WAIT
//  o_mem_read   out  1       RAM read strobe, one cycle in ISSUE
//  o_mem_write  out  1       RAM write strobe, one cycle in ISSUE
//  i_mem_rdata  in   DATA_W  RAM read data, valid with i_mem_done
//  i_mem_done   in   1       RAM completion, sampled only in WAIT
//  o_a_err/o_b_err out 1     present only with RAM_ARB_TIMEOUT_EN; timeout flag, qualified by done
// BEHAVIOUR
//  - Reset: all outputs 0, pending flags clear, state IDLE, last_grant=B (A wins first tie).
//  - Per-port pending register: strobe in cycle T sets pending_x and latches addr/wdata/rw
//    at edge T. Read+write in same cycle = write; read ignored.
//  - Strobe while pending_x already set: dropped (protocol violation), latched request unchanged.
//  - Set of pending_x takes precedence over clear in the same cycle.
//  - FSM IDLE: none pending -> IDLE. One pending -> grant it. Both -> grant port != last_grant.
//    Grant latches port id, addr, wdata, rw into RAM-side registers -> ISSUE.
//  - ISSUE: o_mem_read or o_mem_write high exactly one cycle -> WAIT.
//  - WAIT: hold o_mem_addr/o_mem_wdata. On i_mem_done: reads capture i_mem_rdata into
//    o_x_rdata, o_x_done pulses next cycle, pending_x clears, last_grant=x -> IDLE.
//    Writes: o_x_rdata unchanged.
//  - i_mem_done outside WAIT ignored. Requesting port's strobe and done never overlap.
//  - Min latency: strobe T, IDLE T+1, ISSUE T+2, WAIT+done T+3, o_x_done T+4.
//  - Idle-port o_x_done stays 0; port B never starves (max one A transaction ahead of it).
//  - Reset mid-transaction: abort immediately, discard pending, no done pulse;
//    RAM strobes drop asynchronously.
// CONFIGURATION
//  RAM_ARB_TIMEOUT_EN defined: 8+ bit counter clears on entering WAIT, increments each
//  WAIT cycle without i_mem_done. At TIMEOUT_CYCLES: abandon transaction, pulse o_x_done
//  with o_x_err=1, o_x_rdata=8'hFF, clear pending, update last_grant, -> IDLE.
//  o_x_err=0 on normal completion. Done on the limit cycle counts as normal completion.
//  Undefined: WAIT indefinitely, no counter, no o_*_err ports.
// TESTING
//  - Reset then A read 0x0010, RAM done 1st WAIT cycle with 0x5A -> mem_read at T+2,
//    o_a_done at T+4, o_a_rdata=0x5A.
//  - A write 0x0020=0x33 and B read 0x0030 same cycle -> A served first, then B;
//    o_mem_addr 0x0020 then 0x0030, one done per port.
//  - A requests back-to-back while B pending -> order A,B,A,B; B never waits >1 A transaction.
//  - A read+write same cycle -> single mem_write, no mem_read; 2nd A strobe while pending -> dropped.
//  - Assert i_rst during WAIT -> all outputs 0 same cycle, no o_a_done; next request from IDLE.
//  - RAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, no i_mem_done -> o_b_done+o_b_err, o_b_rdata=0xFF
//    after 4 WAIT cycles; later request completes with err=0.

Source files
------------

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one byte-wide RAM between the CPU data port (A) and a loader/debug port (B).
// Optional WAIT-state timeout with per-port error flags when RAM_ARB_TIMEOUT_EN is defined.
module ram_arbiter #(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [ADDR_W-1:0] i_a_addr,
   input  logic [DATA_W-1:0] i_a_wdata,
   input  logic              i_a_read,
   input  logic              i_a_write,
   output logic [DATA_W-1:0] o_a_rdata,
   output logic              o_a_done,
   input  logic [ADDR_W-1:0] i_b_addr,
   input  logic [DATA_W-1:0] i_b_wdata,
   input  logic              i_b_read,
   input  logic              i_b_write,
   output logic [DATA_W-1:0] o_b_rdata,
   output logic              o_b_done,
`ifdef RAM_ARB_TIMEOUT_EN
   output logic              o_a_err,
   output logic              o_b_err,
`endif
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_mem_read,
   output logic              o_mem_write,
   input  logic [DATA_W-1:0] i_mem_rdata,
   input  logic              i_mem_done
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_t            state;
   logic [1:0]        rd_stb, wr_stb, pend, clr;
   logic [ADDR_W-1:0] addr_in   [2];
   logic [DATA_W-1:0] wdata_in  [2];
   logic [ADDR_W-1:0] req_addr  [2];
   logic [DATA_W-1:0] req_wdata [2];
   logic [1:0]        req_wr;
   logic              gnt, last_grant, mem_wr_q, pick, finish, tmo;

   assign rd_stb      = {i_b_read, i_a_read};
   assign wr_stb      = {i_b_write, i_a_write};
   assign addr_in[0]  = i_a_addr;
   assign addr_in[1]  = i_b_addr;
   assign wdata_in[0] = i_a_wdata;
   assign wdata_in[1] = i_b_wdata;

   // On a tie the port that was not served last wins, so B never waits behind two A transactions.
   assign pick   = (pend == 2'b11) ? ~last_grant : pend[1];
   assign finish = (state == WAIT) && (i_mem_done || tmo);
   assign clr    = {finish && gnt, finish && !gnt};

`ifdef RAM_ARB_TIMEOUT_EN
   logic [CNT_W-1:0] cnt;
   assign tmo = !i_mem_done && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign tmo = 1'b0;
`endif

   // A strobe landing on the completion cycle is accepted: set beats clear.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pend   <= '0;
         req_wr <= '0;
         for (int p = 0; p < 2; p++) begin
            req_addr[p]  <= '0;
            req_wdata[p] <= '0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            if ((rd_stb[p] || wr_stb[p]) && (!pend[p] || clr[p])) begin
               pend[p]      <= 1'b1;
               req_addr[p]  <= addr_in[p];
               req_wdata[p] <= wdata_in[p];
               req_wr[p]    <= wr_stb[p];
            end else if (clr[p]) begin
               pend[p] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= IDLE;
         gnt         <= 1'b0;
         last_grant  <= 1'b1;
         mem_wr_q    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         o_mem_read  <= 1'b0;
         o_mem_write <= 1'b0;
         o_a_rdata   <= '0;
         o_b_rdata   <= '0;
         o_a_done    <= 1'b0;
         o_b_done    <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
         o_a_err     <= 1'b0;
         o_b_err     <= 1'b0;
         cnt         <= '0;
`endif
      end else begin
         o_a_done <= 1'b0;
         o_b_done <= 1'b0;
         case (state)
            IDLE: begin
               if (|pend) begin
                  gnt         <= pick;
                  o_mem_addr  <= req_addr[pick];
                  o_mem_wdata <= req_wdata[pick];
                  mem_wr_q    <= req_wr[pick];
                  o_mem_write <= req_wr[pick];
                  o_mem_read  <= !req_wr[pick];
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               o_mem_read  <= 1'b0;
               o_mem_write <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
               cnt         <= '0;
`endif
               state       <= WAIT;
            end
            WAIT: begin
               if (finish) begin
                  last_grant <= gnt;
                  state      <= IDLE;
                  if (!gnt) begin
                     o_a_done <= 1'b1;
                     if (tmo)            o_a_rdata <= '1;
                     else if (!mem_wr_q) o_a_rdata <= i_mem_rdata;
`ifdef RAM_ARB_TIMEOUT_EN
                     o_a_err  <= tmo;
`endif
                  end else begin
                     o_b_done <= 1'b1;
                     if (tmo)            o_b_rdata <= '1;
                     else if (!mem_wr_q) o_b_rdata <= i_mem_rdata;
`ifdef RAM_ARB_TIMEOUT_EN
                     o_b_err  <= tmo;
`endif
                  end
               end
`ifdef RAM_ARB_TIMEOUT_EN
               else begin
                  cnt <= cnt + 1'b1;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: latency, round-robin order, strobe merging/dropping, reset abort,
// and (with RAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4) the timeout path.
module tb_ram_arbiter;

   localparam int AW = 16;
   localparam int DW = 8;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic [AW-1:0] a_addr = '0, b_addr = '0;
   logic [DW-1:0] a_wdata = '0, b_wdata = '0;
   logic          a_read = 0, a_write = 0, b_read = 0, b_write = 0;
   logic [DW-1:0] a_rdata, b_rdata;
   logic          a_done, b_done;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_read, mem_write;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_done = 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
   logic          a_err, b_err;
`endif

   int errors = 0;
   int checks = 0;

   always #5 i_clk = ~i_clk;

   ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_a_addr(a_addr), .i_a_wdata(a_wdata), .i_a_read(a_read), .i_a_write(a_write),
      .o_a_rdata(a_rdata), .o_a_done(a_done),
      .i_b_addr(b_addr), .i_b_wdata(b_wdata), .i_b_read(b_read), .i_b_write(b_write),
      .o_b_rdata(b_rdata), .o_b_done(b_done),
`ifdef RAM_ARB_TIMEOUT_EN
      .o_a_err(a_err), .o_b_err(b_err),
`endif
      .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .o_mem_read(mem_read), .o_mem_write(mem_write),
      .i_mem_rdata(mem_rdata), .i_mem_done(mem_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic clear_strobes();
      a_read = 0; a_write = 0; b_read = 0; b_write = 0;
   endtask

   // Wait (bounded) for the RAM strobe, check it, step into WAIT and optionally raise done.
   task automatic issue(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                        input logic do_done, input logic [DW-1:0] rd, input string tag);
      int n = 0;
      while (!(mem_read || mem_write) && n < 20) begin
         cyc();
         n++;
      end
      chk({tag, "_strobe_seen"}, 32'(mem_read || mem_write), 1);
      chk({tag, "_addr"}, 32'(mem_addr), 32'(addr));
      chk({tag, "_write"}, 32'(mem_write), 32'(wr));
      chk({tag, "_read"}, 32'(mem_read), 32'(!wr));
      if (wr) chk({tag, "_wdata"}, 32'(mem_wdata), 32'(wd));
      cyc();
      chk({tag, "_wait_hold"}, 32'({mem_read, mem_write, mem_addr}), 32'({2'b00, addr}));
      if (do_done) begin
         mem_done  = 1'b1;
         mem_rdata = rd;
      end
   endtask

   task automatic complete();
      cyc();
      mem_done = 1'b0;
      clear_strobes();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      // reset state
      #1;
      chk("rst_outputs", 32'({a_done, b_done, mem_read, mem_write}), 0);
      chk("rst_addr", 32'(mem_addr), 0);
      chk("rst_rdata", 32'({a_rdata, b_rdata}), 0);
      cyc(); cyc();
      i_rst = 0;
      cyc();

      // A read 0x0010, minimum latency
      a_read = 1; a_addr = 16'h0010;
      cyc(); clear_strobes();
      chk("t1_idle_noread", 32'(mem_read), 0);
      cyc();
      chk("t1_issue_read", 32'(mem_read), 1);
      chk("t1_issue_addr", 32'(mem_addr), 32'h0010);
      chk("t1_issue_nowrite", 32'(mem_write), 0);
      cyc();
      chk("t1_wait_read_low", 32'(mem_read), 0);
      chk("t1_wait_nodone", 32'(a_done), 0);
      mem_done = 1; mem_rdata = 8'h5A;
      cyc(); mem_done = 0;
      chk("t1_done", 32'(a_done), 1);
      chk("t1_rdata", 32'(a_rdata), 32'h5A);
      chk("t1_b_idle", 32'(b_done), 0);
`ifdef RAM_ARB_TIMEOUT_EN
      chk("t1_err", 32'(a_err), 0);
`endif
      cyc();
      chk("t1_done_pulse", 32'(a_done), 0);
      chk("t1_rdata_held", 32'(a_rdata), 32'h5A);

      // reset during WAIT
      a_read = 1; a_addr = 16'h00A0;
      cyc(); clear_strobes();
      issue(16'h00A0, 0, 0, 0, 0, "t5");
      #2 i_rst = 1;
      #1;
      chk("t5_rst_addr", 32'(mem_addr), 0);
      chk("t5_rst_outs", 32'({a_done, b_done, mem_read, mem_write}), 0);
      chk("t5_rst_rdata", 32'(a_rdata), 0);
      cyc();
      i_rst = 0;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (a_done || b_done || mem_read || mem_write) cnt++;
         cyc();
      end
      chk("t5_no_activity", 32'(cnt), 0);
      b_read = 1; b_addr = 16'h00B0;
      cyc(); clear_strobes();
      cyc();
      chk("t5_b_issue", 32'({mem_read, mem_addr}), 32'({1'b1, 16'h00B0}));
      cyc();
      mem_done = 1; mem_rdata = 8'h3C;
      cyc(); mem_done = 0;
      chk("t5_b_done", 32'({a_done, b_done}), 32'b01);
      chk("t5_b_rdata", 32'(b_rdata), 32'h3C);

      // simultaneous A write and B read, last grant was B -> A first
      a_write = 1; a_addr = 16'h0020; a_wdata = 8'h33;
      b_read = 1; b_addr = 16'h0030;
      cyc(); clear_strobes();
      issue(16'h0020, 1, 8'h33, 1, 8'hEE, "t2a");
      complete();
      chk("t2a_done", 32'({a_done, b_done}), 32'b10);
      issue(16'h0030, 0, 0, 1, 8'hE1, "t2b");
      complete();
      chk("t2b_done", 32'({a_done, b_done}), 32'b01);
      chk("t2b_rdata", 32'(b_rdata), 32'hE1);
      chk("t2a_rdata_unchanged", 32'(a_rdata), 0);

      // back-to-back requests re-armed on the completion cycle: A,B,A,B
      a_read = 1; a_addr = 16'h0040;
      b_read = 1; b_addr = 16'h0050;
      cyc(); clear_strobes();
      issue(16'h0040, 0, 0, 1, 8'h41, "t3a1");
      a_read = 1; a_addr = 16'h0060;
      complete();
      chk("t3a1_done", 32'({a_done, a_rdata}), 32'({1'b1, 8'h41}));
      issue(16'h0050, 0, 0, 1, 8'h51, "t3b1");
      b_read = 1; b_addr = 16'h0070;
      complete();
      chk("t3b1_done", 32'({b_done, b_rdata}), 32'({1'b1, 8'h51}));
      issue(16'h0060, 0, 0, 1, 8'h61, "t3a2");
      complete();
      chk("t3a2_done", 32'({a_done, a_rdata}), 32'({1'b1, 8'h61}));
      issue(16'h0070, 0, 0, 1, 8'h71, "t3b2");
      complete();
      chk("t3b2_done", 32'({b_done, b_rdata}), 32'({1'b1, 8'h71}));

      // read+write together -> write; second strobe while pending is dropped
      a_read = 1; a_write = 1; a_addr = 16'h0080; a_wdata = 8'h11;
      cyc();
      a_read = 0; a_write = 1; a_addr = 16'h0090; a_wdata = 8'h22;
      cyc(); clear_strobes();
      issue(16'h0080, 1, 8'h11, 1, 8'h99, "t4");
      complete();
      chk("t4_done", 32'({a_done, b_done}), 32'b10);
      chk("t4_rdata_unchanged", 32'(a_rdata), 32'h61);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         if (mem_read || mem_write || a_done || b_done) cnt++;
      end
      chk("t4_dropped", 32'(cnt), 0);

`ifdef RAM_ARB_TIMEOUT_EN
      // no RAM done: timeout after 4 WAIT cycles
      b_read = 1; b_addr = 16'h00C0;
      cyc(); clear_strobes();
      issue(16'h00C0, 0, 0, 0, 0, "t6");
      cyc(); cyc(); cyc();
      chk("t6_no_early_done", 32'(b_done), 0);
      cyc();
      chk("t6_tmo_done", 32'({b_done, b_err}), 32'b11);
      chk("t6_tmo_rdata", 32'(b_rdata), 32'hFF);
      chk("t6_a_idle", 32'(a_done), 0);
      cyc();
      chk("t6_done_pulse", 32'(b_done), 0);
      b_read = 1; b_addr = 16'h00D0;
      cyc(); clear_strobes();
      issue(16'h00D0, 0, 0, 1, 8'hD5, "t6b");
      complete();
      chk("t6b_ok", 32'({b_done, b_err}), 32'b10);
      chk("t6b_rdata", 32'(b_rdata), 32'hD5);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
